// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Bus widths, FSM state encoding and grant vectors.
package wb_arb_pkg;

  localparam int AW = 16;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    GNT1,
    GNT2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M1   = 2'b01;
  localparam logic [1:0] GNT_M2   = 2'b10;

  function automatic logic [1:0] gnt_of(arb_state_t s);
    logic [1:0] g;
    g = GNT_NONE;
    unique case (s)
      GNT1:    g = GNT_M1;
      GNT2:    g = GNT_M2;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bus bundle.
// dat_o carries master write data, dat_i carries read data back.
interface if_wb;
  import wb_arb_pkg::*;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          ack;
  logic          stall;

  modport master (
    output cyc, stb, we, adr, dat_o,
    input  dat_i, ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat_o,
    output dat_i, ack, stall
  );

endinterface

// File: rtl/wb_arb_txn_tracker.sv
// Outstanding-request counter and no-ack watchdog
// for the currently granted master.
module wb_arb_txn_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic accept,
  input  logic ack,
  output logic full,
  output logic expired
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [OW-1:0] out;
  logic [WW-1:0] wd;

  assign full    = (out == OW'(MAX_OUTSTANDING));
  assign expired = (TIMEOUT != 0) && (wd == WW'(TIMEOUT));

  // A stray ack with nothing in flight must not wrap the count.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      out <= '0;
    end else if (accept && !ack) begin
      out <= out + OW'(1);
    end else if (ack && !accept && out != '0) begin
      out <= out - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr || ack || TIMEOUT == 0) begin
      wd <= '0;
    end else if (out != '0 && !expired) begin
      wd <= wd + WW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter sharing one pipelined Wishbone
// slave between two masters, with a no-ack watchdog.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic       clk,
  input  logic       reset,
  if_wb.slave        wbm1,
  if_wb.slave        wbm2,
  if_wb.master       wbs,
  output logic [1:0] gnt,
  output logic       timeout
);

  arb_state_t state;
  arb_state_t state_n;
  arb_state_t last;

  logic blk1;
  logic blk2;
  logic req1;
  logic req2;
  logic own_cyc;
  logic fire;
  logic rel;
  logic full;
  logic expired;
  logic accept;
  logic trk_ack;
  logic trk_clr;

  // A watchdog-released master stays out until it drops cyc
  // or the other master has had the bus.
  assign req1 = wbm1.cyc && !blk1;
  assign req2 = wbm2.cyc && !blk2;

  always_comb begin
    state_n = state;
    fire    = 1'b0;
    own_cyc = 1'b0;
    unique case (state)
      IDLE: begin
        if (req1 && req2) begin
          state_n = (last == GNT1) ? GNT2 : GNT1;
        end else if (req1) begin
          state_n = GNT1;
        end else if (req2) begin
          state_n = GNT2;
        end
      end
      GNT1, GNT2: begin
        own_cyc = (state == GNT1) ? wbm1.cyc : wbm2.cyc;
        if (expired) begin
          state_n = IDLE;
          fire    = 1'b1;
        end else if (!own_cyc) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rel = (state != IDLE) && (state_n == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      last    <= GNT2;
      timeout <= 1'b0;
      blk1    <= 1'b0;
      blk2    <= 1'b0;
    end else begin
      state   <= state_n;
      timeout <= fire;
      if (rel) begin
        last <= state;
      end
      blk1 <= (fire && state == GNT1 && wbm1.cyc)
           || (blk1 && wbm1.cyc && state != GNT2);
      blk2 <= (fire && state == GNT2 && wbm2.cyc)
           || (blk2 && wbm2.cyc && state != GNT1);
    end
  end

  assign gnt = gnt_of(state);

  always_comb begin
    wbs.cyc    = 1'b0;
    wbs.stb    = 1'b0;
    wbs.we     = 1'b0;
    wbs.adr    = '0;
    wbs.dat_o  = '0;
    wbm1.stall = 1'b1;
    wbm1.ack   = 1'b0;
    wbm2.stall = 1'b1;
    wbm2.ack   = 1'b0;
    unique case (state)
      GNT1: begin
        wbs.cyc    = wbm1.cyc;
        wbs.stb    = wbm1.stb && !full;
        wbs.we     = wbm1.we;
        wbs.adr    = wbm1.adr;
        wbs.dat_o  = wbm1.dat_o;
        wbm1.stall = wbs.stall || full;
        wbm1.ack   = wbs.ack;
      end
      GNT2: begin
        wbs.cyc    = wbm2.cyc;
        wbs.stb    = wbm2.stb && !full;
        wbs.we     = wbm2.we;
        wbs.adr    = wbm2.adr;
        wbs.dat_o  = wbm2.dat_o;
        wbm2.stall = wbs.stall || full;
        wbm2.ack   = wbs.ack;
      end
      default: ;
    endcase
  end

  assign wbm1.dat_i = wbs.dat_i;
  assign wbm2.dat_i = wbs.dat_i;

  // Acks seen while idle belong to an abandoned cycle.
  assign accept  = wbs.stb && !wbs.stall;
  assign trk_ack = wbs.ack && (state != IDLE);
  assign trk_clr = (state == IDLE) || rel;

  wb_arb_txn_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT         (TIMEOUT)
  ) u_trk (
    .clk     (clk),
    .reset   (reset),
    .clr     (trk_clr),
    .accept  (accept),
    .ack     (trk_ack),
    .full    (full),
    .expired (expired)
  );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: one arbiter with a
// short watchdog, one with a shallow pipeline limit.
module tb_wb_arbiter2;
  import wb_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] gnt_a;
  logic [1:0] gnt_b;
  logic       to_a;
  logic       to_b;
  int         vec = 0;
  int         errs = 0;

  if_wb m1();
  if_wb m2();
  if_wb s();
  if_wb b1();
  if_wb b2();
  if_wb bs();

  wb_arbiter2 #(.MAX_OUTSTANDING(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .reset(reset), .wbm1(m1), .wbm2(m2),
    .wbs(s), .gnt(gnt_a), .timeout(to_a)
  );

  wb_arbiter2 #(.MAX_OUTSTANDING(2), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .wbm1(b1), .wbm2(b2),
    .wbs(bs), .gnt(gnt_b), .timeout(to_b)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m1.cyc = 0; m1.stb = 0; m1.we = 0; m1.adr = '0; m1.dat_o = '0;
    m2.cyc = 0; m2.stb = 0; m2.we = 0; m2.adr = '0; m2.dat_o = '0;
    b1.cyc = 0; b1.stb = 0; b1.we = 0; b1.adr = '0; b1.dat_o = '0;
    b2.cyc = 0; b2.stb = 0; b2.we = 0; b2.adr = '0; b2.dat_o = '0;
    s.ack = 0; s.stall = 0; s.dat_i = '0;
    bs.ack = 0; bs.stall = 0; bs.dat_i = '0;
  endtask

  task automatic test_reset;
    reset = 1;
    idle_inputs();
    tick();
    tick();
    vec++; if (gnt_a !== 2'b00) begin errs++;
      $display("FAIL rst_gnt: got %b want 00", gnt_a); end
    vec++; if ({to_a, to_b} !== 2'b00) begin errs++;
      $display("FAIL rst_timeout: got %b want 00", {to_a, to_b}); end
    vec++; if ({s.cyc, s.stb} !== 2'b00) begin errs++;
      $display("FAIL rst_wbs: got %b want 00", {s.cyc, s.stb}); end
    vec++; if ({m1.stall, m2.stall} !== 2'b11) begin errs++;
      $display("FAIL rst_stall: got %b want 11", {m1.stall, m2.stall}); end
    vec++; if ({m1.ack, m2.ack} !== 2'b00) begin errs++;
      $display("FAIL rst_ack: got %b want 00", {m1.ack, m2.ack}); end
    vec++; if (gnt_b !== 2'b00) begin errs++;
      $display("FAIL rst_gnt_b: got %b want 00", gnt_b); end
    reset = 0;
    tick();
  endtask

  task automatic test_single;
    int nack;
    nack = 0;
    m1.cyc = 1; m1.stb = 1; m1.adr = 16'h0010;
    #1;
    vec++; if (gnt_a !== 2'b00) begin errs++;
      $display("FAIL t1_latency: got %b want 00", gnt_a); end
    tick();
    for (int k = 0; k < 4; k++) begin
      m1.stb = (k < 3);
      m1.adr = 16'h0010 + 16'(k);
      s.ack = (k >= 1);
      s.dat_i = 16'hA000 + 16'(k);
      #1;
      vec++; if (gnt_a !== 2'b01) begin errs++;
        $display("FAIL t1_gnt: got %b want 01", gnt_a); end
      vec++; if (m2.stall !== 1'b1) begin errs++;
        $display("FAIL t1_loser_stall: got %b want 1", m2.stall); end
      vec++; if (m1.ack !== (k >= 1)) begin errs++;
        $display("FAIL t1_ack: got %b want %b", m1.ack, (k >= 1)); end
      if (k < 3) begin
        vec++; if ({s.stb, s.adr} !== {1'b1, 16'h0010 + 16'(k)}) begin errs++;
          $display("FAIL t1_route: got %h want %h", {s.stb, s.adr},
                   {1'b1, 16'h0010 + 16'(k)}); end
      end
      if (k >= 1) begin
        vec++; if (m1.dat_i !== 16'hA000 + 16'(k)) begin errs++;
          $display("FAIL t1_rdata: got %h want %h", m1.dat_i, 16'hA000 + 16'(k)); end
      end
      if (m1.ack === 1'b1) nack++;
      tick();
    end
    m1.cyc = 0; m1.stb = 0; s.ack = 0;
    #1;
    vec++; if (s.cyc !== 1'b0) begin errs++;
      $display("FAIL t1_cyc_drop: got %b want 0", s.cyc); end
    tick();
    vec++; if (gnt_a !== 2'b00) begin errs++;
      $display("FAIL t1_release: got %b want 00", gnt_a); end
    vec++; if (nack !== 3) begin errs++;
      $display("FAIL t1_nack: got %0d want 3", nack); end
    vec++; if (dut_a.u_trk.out !== 3'd0) begin errs++;
      $display("FAIL t1_out: got %0d want 0", dut_a.u_trk.out); end
  endtask

  task automatic test_round_robin;
    reset = 1;
    tick();
    reset = 0;
    m1.cyc = 1; m2.cyc = 1;
    tick();
    vec++; if (gnt_a !== 2'b01) begin errs++;
      $display("FAIL t2_first: got %b want 01", gnt_a); end
    vec++; if (m2.stall !== 1'b1) begin errs++;
      $display("FAIL t2_wait_stall: got %b want 1", m2.stall); end
    m1.cyc = 0;
    tick();
    vec++; if (gnt_a !== 2'b00) begin errs++;
      $display("FAIL t2_dead: got %b want 00", gnt_a); end
    tick();
    vec++; if ({gnt_a, s.cyc} !== 3'b101) begin errs++;
      $display("FAIL t2_second: got %b want 101", {gnt_a, s.cyc}); end
    m2.cyc = 0; m1.cyc = 1;
    tick();
    vec++; if (gnt_a !== 2'b00) begin errs++;
      $display("FAIL t2_dead2: got %b want 00", gnt_a); end
    m2.cyc = 1;
    tick();
    vec++; if (gnt_a !== 2'b01) begin errs++;
      $display("FAIL t2_alt: got %b want 01", gnt_a); end
    m1.cyc = 0;
    tick();
    tick();
    vec++; if (gnt_a !== 2'b10) begin errs++;
      $display("FAIL t2_alt2: got %b want 10", gnt_a); end
    m2.cyc = 0;
    tick();
    tick();
  endtask

  task automatic test_same_cycle_ack;
    m1.cyc = 1; m1.stb = 1;
    tick();
    tick();
    vec++; if (dut_a.u_trk.out !== 3'd1) begin errs++;
      $display("FAIL t5_out1: got %0d want 1", dut_a.u_trk.out); end
    s.ack = 1;
    tick();
    vec++; if (dut_a.u_trk.out !== 3'd1) begin errs++;
      $display("FAIL t5_acc_ack: got %0d want 1", dut_a.u_trk.out); end
    m1.stb = 0;
    tick();
    vec++; if (dut_a.u_trk.out !== 3'd0) begin errs++;
      $display("FAIL t5_drain: got %0d want 0", dut_a.u_trk.out); end
    #1;
    vec++; if ({m1.ack, m2.ack} !== 2'b10) begin errs++;
      $display("FAIL t5_fwd: got %b want 10", {m1.ack, m2.ack}); end
    tick();
    vec++; if (dut_a.u_trk.out !== 3'd0) begin errs++;
      $display("FAIL t5_spur: got %0d want 0", dut_a.u_trk.out); end
    s.ack = 0; m1.cyc = 0;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    m1.cyc = 1; m1.stb = 1;
    tick();
    tick();
    m1.stb = 0; m2.cyc = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vec++; if ({to_a, gnt_a} !== 3'b001) begin errs++;
        $display("FAIL t4_wait%0d: got %b want 001", i, {to_a, gnt_a}); end
    end
    tick();
    vec++; if ({to_a, gnt_a, s.cyc} !== 4'b1000) begin errs++;
      $display("FAIL t4_fire: got %b want 1000", {to_a, gnt_a, s.cyc}); end
    tick();
    vec++; if ({to_a, gnt_a} !== 3'b010) begin errs++;
      $display("FAIL t4_handover: got %b want 010", {to_a, gnt_a}); end
    m2.cyc = 0;
    tick();
    tick();
    vec++; if (gnt_a !== 2'b01) begin errs++;
      $display("FAIL t4_regrant: got %b want 01", gnt_a); end
    m1.stb = 1;
    tick();
    m1.stb = 0;
    for (int i = 0; i < 8; i++) tick();
    tick();
    vec++; if ({to_a, gnt_a} !== 3'b100) begin errs++;
      $display("FAIL t4_fire2: got %b want 100", {to_a, gnt_a}); end
    tick();
    vec++; if (gnt_a !== 2'b00) begin errs++;
      $display("FAIL t4_blocked: got %b want 00", gnt_a); end
    m1.cyc = 0;
    tick();
    m1.cyc = 1;
    tick();
    vec++; if (gnt_a !== 2'b01) begin errs++;
      $display("FAIL t4_after_drop: got %b want 01", gnt_a); end
    m1.cyc = 0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    m2.cyc = 1; m2.stb = 1;
    tick();
    tick();
    tick();
    tick();
    vec++; if ({gnt_a, dut_a.u_trk.out} !== {2'b10, 3'd3}) begin errs++;
      $display("FAIL t6_setup: got %b want 10011", {gnt_a, dut_a.u_trk.out}); end
    reset = 1; m1.cyc = 1;
    tick();
    vec++; if ({gnt_a, s.cyc, dut_a.u_trk.out} !== 6'b000000) begin errs++;
      $display("FAIL t6_abandon: got %b want 000000",
               {gnt_a, s.cyc, dut_a.u_trk.out}); end
    reset = 0; s.ack = 1;
    #1;
    vec++; if (m2.ack !== 1'b0) begin errs++;
      $display("FAIL t6_late_ack: got %b want 0", m2.ack); end
    tick();
    vec++; if (gnt_a !== 2'b01) begin errs++;
      $display("FAIL t6_m1_first: got %b want 01", gnt_a); end
    s.ack = 0; m1.cyc = 0; m2.cyc = 0; m2.stb = 0;
    tick();
    tick();
  endtask

  task automatic test_full;
    int c, sent, nack, mout, maxo;
    int due[$];
    logic [15:0] tag[$];
    logic ack_now, acc;
    c = 0; sent = 0; nack = 0; mout = 0; maxo = 0;
    b1.cyc = 1; b1.we = 1;
    tick();
    while (nack < 4 && c < 60) begin
      b1.stb = (sent < 4);
      b1.adr = 16'(sent);
      ack_now = (due.size() > 0) && (due[0] == c);
      bs.ack = ack_now;
      bs.dat_i = ack_now ? tag[0] : 16'h0;
      #1;
      if (mout == 2) begin
        vec++; if (bs.stb !== 1'b0) begin errs++;
          $display("FAIL t3_stb_full: got %b want 0", bs.stb); end
        vec++; if (b1.stall !== 1'b1) begin errs++;
          $display("FAIL t3_stall_full: got %b want 1", b1.stall); end
      end
      if (ack_now) begin
        vec++; if ({b1.ack, b1.dat_i} !== {1'b1, 16'(nack)}) begin errs++;
          $display("FAIL t3_order: got %h want %h", {b1.ack, b1.dat_i},
                   {1'b1, 16'(nack)}); end
        nack++;
        void'(due.pop_front());
        void'(tag.pop_front());
      end
      acc = bs.stb && !bs.stall;
      if (acc) begin
        due.push_back(c + 5);
        tag.push_back(bs.adr);
        sent++;
      end
      mout = mout + int'(acc) - int'(ack_now);
      if (mout > maxo) maxo = mout;
      tick();
      c++;
    end
    vec++; if (nack !== 4) begin errs++;
      $display("FAIL t3_all_acked: got %0d want 4", nack); end
    vec++; if (maxo !== 2) begin errs++;
      $display("FAIL t3_reached_full: got %0d want 2", maxo); end
    vec++; if (b2.stall !== 1'b1) begin errs++;
      $display("FAIL t3_loser: got %b want 1", b2.stall); end
    b1.cyc = 0; b1.stb = 0; bs.ack = 0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_same_cycle_ack();
    test_timeout();
    test_reset_mid();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
